// File: rtl/trig_edge_conditioner.sv
// Trigger edge conditioner: two independent channels (start, stop), each synchronised,
// width-filtered, rising-edge detected and holdoff-gated into a single-cycle pulse.
// Accepted and holdoff-refused events are counted for monitoring.
module trig_edge_conditioner #(
    parameter int unsigned MIN_WIDTH = 2,
    parameter int unsigned HOLDOFF   = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start_in,
    input  logic             stop_in,
    output logic             set_pulse,
    output logic             clr_pulse,
    output logic [CNT_W-1:0] set_count,
    output logic [CNT_W-1:0] clr_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned WW = $clog2(MIN_WIDTH + 1);
    // Keep at least one bit so HOLDOFF=0 still yields a legal (always-zero) counter.
    localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [WW-1:0] WMax  = WW'(MIN_WIDTH);
    localparam logic [HW-1:0] HLoad = HW'(HOLDOFF);

    // Channel index 0 = start, 1 = stop.
    logic [1:0]       raw;
    logic [1:0]       s1_q, s2_q;
    logic [WW-1:0]    wcnt_q [2];
    logic [WW-1:0]    wcnt_d [2];
    logic [HW-1:0]    hcnt_q [2];
    logic [HW-1:0]    hcnt_d [2];
    logic [1:0]       pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W:0]   drop_sum;
    logic [1:0]       qual, accept, drop;

    assign raw = {stop_in, start_in};

    // Per-channel width filter, qualification, holdoff and acceptance.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            if (!s2_q[c]) begin
                wcnt_d[c] = '0;
            end else if (wcnt_q[c] != WMax) begin
                wcnt_d[c] = wcnt_q[c] + WW'(1);
            end else begin
                wcnt_d[c] = wcnt_q[c];
            end
            // Only the transition into saturation qualifies: once per high level.
            qual[c]   = (wcnt_d[c] == WMax) && (wcnt_q[c] != WMax);
            accept[c] = qual[c] && enable && (hcnt_q[c] == '0);
            drop[c]   = qual[c] && enable && (hcnt_q[c] != '0);
            if (accept[c]) begin
                hcnt_d[c] = HLoad;
            end else if (hcnt_q[c] != '0) begin
                hcnt_d[c] = hcnt_q[c] - HW'(1);
            end else begin
                hcnt_d[c] = hcnt_q[c];
            end
            pulse_d[c] = accept[c];
            cnt_d[c]   = cnt_q[c] + CNT_W'(accept[c]);
        end
    end

    // Drop counter: both channels may refuse in the same cycle; saturate at all-ones.
    always_comb begin
        drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop[0]) + (CNT_W + 1)'(drop[1]);
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            wcnt_q  <= '{default: '0};
            hcnt_q  <= '{default: '0};
            pulse_q <= '0;
            cnt_q   <= '{default: '0};
            drop_q  <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign set_pulse  = pulse_q[0];
    assign clr_pulse  = pulse_q[1];
    assign set_count  = cnt_q[0];
    assign clr_count  = cnt_q[1];
    assign drop_count = drop_q;

endmodule

// File: tb/tb_trig_edge_conditioner.sv
// Bench for trig_edge_conditioner: directed vector table, hand-written corner sequences and
// randomized stimulus against a level/run-length reference model, across three parameter sets.
module tb_trig_edge_conditioner;

    localparam int NI = 3;
    localparam int MW [NI] = '{2, 2, 1};
    localparam int HO [NI] = '{8, 0, 3};
    localparam int CW [NI] = '{16, 4, 4};

    logic clk;
    logic reset;
    logic enable;
    logic start_in;
    logic stop_in;

    logic        sp [NI];
    logic        cp [NI];
    logic [15:0] sc [NI];
    logic [15:0] cc [NI];
    logic [15:0] dc [NI];
    logic [3:0]  sc1_w, cc1_w, dc1_w, sc2_w, cc2_w, dc2_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    trig_edge_conditioner #(.MIN_WIDTH(2), .HOLDOFF(8), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .start_in(start_in), .stop_in(stop_in),
        .set_pulse(sp[0]), .clr_pulse(cp[0]),
        .set_count(sc[0]), .clr_count(cc[0]), .drop_count(dc[0])
    );
    trig_edge_conditioner #(.MIN_WIDTH(2), .HOLDOFF(0), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .start_in(start_in), .stop_in(stop_in),
        .set_pulse(sp[1]), .clr_pulse(cp[1]),
        .set_count(sc1_w), .clr_count(cc1_w), .drop_count(dc1_w)
    );
    trig_edge_conditioner #(.MIN_WIDTH(1), .HOLDOFF(3), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .start_in(start_in), .stop_in(stop_in),
        .set_pulse(sp[2]), .clr_pulse(cp[2]),
        .set_count(sc2_w), .clr_count(cc2_w), .drop_count(dc2_w)
    );

    assign sc[1] = {12'd0, sc1_w};
    assign cc[1] = {12'd0, cc1_w};
    assign dc[1] = {12'd0, dc1_w};
    assign sc[2] = {12'd0, sc2_w};
    assign cc[2] = {12'd0, cc2_w};
    assign dc[2] = {12'd0, dc2_w};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the conditioned level is the raw input delayed two samples; an edge
    // qualifies when the current run of highs reaches exactly MIN_WIDTH; acceptance needs
    // more than HOLDOFF edges since the previous acceptance on that channel.
    logic dl    [NI][2][2];
    int   run   [NI][2];
    int   last  [NI][2];
    logic mp    [NI][2];
    int   mcnt  [NI][2];
    int   mdrop [NI];
    int   k = 0;

    task automatic model_step(input logic rst, input logic st, input logic spi, input logic en);
        int   nd;
        logic x;
        logic used;
        int   lim;
        k++;
        for (int i = 0; i < NI; i++) begin
            nd  = 0;
            lim = (1 << CW[i]) - 1;
            for (int c = 0; c < 2; c++) begin
                x = (c == 0) ? st : spi;
                if (!rst) begin
                    dl[i][c][0] = 1'b0;
                    dl[i][c][1] = 1'b0;
                    run[i][c]   = 0;
                    last[i][c]  = -1000000;
                    mp[i][c]    = 1'b0;
                    mcnt[i][c]  = 0;
                end else begin
                    used        = dl[i][c][0];
                    dl[i][c][0] = dl[i][c][1];
                    dl[i][c][1] = x;
                    run[i][c]   = used ? run[i][c] + 1 : 0;
                    mp[i][c]    = 1'b0;
                    if (run[i][c] == MW[i] && en) begin
                        if (k - last[i][c] > HO[i]) begin
                            mp[i][c]   = 1'b1;
                            last[i][c] = k;
                            mcnt[i][c] = (mcnt[i][c] + 1) % (lim + 1);
                        end else begin
                            nd++;
                        end
                    end
                end
            end
            if (!rst) mdrop[i] = 0;
            else      mdrop[i] = (mdrop[i] + nd > lim) ? lim : mdrop[i] + nd;
        end
    endtask

    task automatic compare_model();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rnd u%0d", i), {sp[i], cp[i], sc[i], cc[i], dc[i]},
                  {mp[i][0], mp[i][1], 16'(mcnt[i][0]), 16'(mcnt[i][1]), 16'(mdrop[i])});
        end
    endtask

    // One clock: drive on the falling edge, let the rising edge act, sample 1 unit later.
    task automatic tick(input logic rst, input logic st, input logic spi, input logic en);
        @(negedge clk);
        reset    = rst;
        start_in = st;
        stop_in  = spi;
        enable   = en;
        @(posedge clk);
        model_step(rst, st, spi, en);
        #1;
    endtask

    typedef struct {
        logic rst;
        logic st;
        logic sp;
        logic en;
        logic es;
        logic ec;
        int   sc;
        int   cc;
        int   dc;
    } vec_t;

    vec_t tbl [$];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach its end, got running expected done");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic val [2];
        int   rem [2];
        int   np;
        logic st;

        reset    = 1'b0;
        enable   = 1'b1;
        start_in = 1'b0;
        stop_in  = 1'b0;

        // Vector table for the default instance: 2 reset rows, then 57 functional rows.
        for (int r = 0; r < 2; r++) begin
            v = '{default: 0};
            v.en = 1'b1;
            tbl.push_back(v);
        end
        for (int t = 0; t < 57; t++) begin
            v.rst = 1'b1;
            v.st  = (t <= 9) || (t == 14) || (t == 17) || (t == 18) || (t >= 30 && t <= 32) ||
                    (t >= 42 && t <= 45) || (t >= 50 && t <= 53);
            v.sp  = (t >= 30 && t <= 32);
            v.en  = !(t >= 40 && t <= 48);
            v.es  = (t == 3) || (t == 20) || (t == 33) || (t == 53);
            v.ec  = (t == 33);
            v.sc  = int'(t >= 3) + int'(t >= 20) + int'(t >= 33) + int'(t >= 53);
            v.cc  = int'(t >= 33);
            v.dc  = 0;
            tbl.push_back(v);
        end

        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].en);
            check($sformatf("vec[%0d]", i), {sp[0], cp[0], sc[0], cc[0], dc[0]},
                  {tbl[i].es, tbl[i].ec, tbl[i].sc[15:0], tbl[i].cc[15:0], tbl[i].dc[15:0]});
        end

        // Holdoff refusal, then acceptance once holdoff has expired.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 20; j++) begin
            st = (j <= 3) || (j >= 6 && j <= 9) || (j >= 15 && j <= 17);
            tick(1'b1, st, 1'b0, 1'b1);
            if (j == 3) check("h1 first accept", sp[0], 1);
            if (j == 9) check("h1 drop", {sp[0], dc[0], sc[0]}, {1'b0, 16'd1, 16'd1});
            if (j == 18) check("h1 third accept", {sp[0], sc[0], dc[0]}, {1'b1, 16'd2, 16'd1});
        end

        // Reset in the middle of holdoff, then again in the middle of a pulse.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j <= 30; j++) begin
            st = (j % 12) <= 2 && j < 27;
            tick(1'b1, st, 1'b0, 1'b1);
        end
        check("h2 before reset", sc[0], 3);
        #2;
        reset = 1'b0;
        #1;
        check("h2 async clear", {sp[0], cp[0], sc[0], cc[0], dc[0]}, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) tick(1'b1, j < 3, 1'b0, 1'b1);
        check("h2 no residual holdoff", {sp[0], sc[0]}, {1'b1, 16'd1});
        reset = 1'b0;
        #1;
        check("h2 pulse abort", {sp[0], sc[0]}, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Counter wrap on the 4-bit, no-holdoff instance.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        np = 0;
        for (int j = 0; j < 64; j++) begin
            tick(1'b1, (j % 4) < 2, 1'b0, 1'b1);
            np += int'(sp[1]);
            if (j == 59) check("h3 count 15", sc[1], 15);
        end
        check("h3 wrap to 0", sc[1], 0);
        check("h3 pulses seen", np, 16);

        // Drop saturation on the MIN_WIDTH=1, HOLDOFF=3 instance, both channels dropping.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 60; j++) begin
            tick(1'b1, (j % 2) == 0, (j % 2) == 0, 1'b1);
            if (j == 30) check("h4 drops 14", {dc[2], sc[2]}, {16'd14, 16'd8});
            if (j == 32) check("h4 drops sat", dc[2], 15);
        end
        check("h4 drops stick", dc[2], 15);

        // Randomized levels of random length (1..12) against the reference model.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        val[0] = 1'b0;
        val[1] = 1'b0;
        rem[0] = 0;
        rem[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0) begin
                    val[c] = ~val[c];
                    rem[c] = $urandom_range(1, 12);
                end
                rem[c]--;
            end
            tick(!(n == 1500 || n == 1501), val[0], val[1], $urandom_range(0, 9) != 0);
            compare_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trig_edge_conditioner.md
Name: trig_edge_conditioner

Overview:
Upstream stage of the set/clear gate logic in the DAQ trigger path. It takes two asynchronous discriminator lines, start and stop, and conditions each one independently: synchronise, filter out glitches, detect the rising edge and apply a holdoff. Each accepted edge becomes a single-cycle set_pulse or clr_pulse for the downstream gate, where set has priority. The block also keeps accepted-event and dropped-event counters for monitoring.

Parameters:
MIN_WIDTH, 2, consecutive synchronised-high cycles required before an edge is accepted; legal range >=1
HOLDOFF, 8, cycles after an accepted edge during which a new acceptance on that channel is refused; 0 disables holdoff
CNT_W, 16, width of all event counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  when low, no pulses are issued and counters hold; synchronisers and filters keep running
start_in  in  1  asynchronous start discriminator line, active high
stop_in  in  1  asynchronous stop discriminator line, active high
set_pulse  out  1  one-cycle pulse per accepted start edge
clr_pulse  out  1  one-cycle pulse per accepted stop edge
set_count  out  CNT_W  accepted start edges, wraps
clr_count  out  CNT_W  accepted stop edges, wraps
drop_count  out  CNT_W  qualified edges refused by holdoff (both channels), saturates at all-ones

Behaviour:
- Reset (reset=0, asynchronous): every register and output is 0, including synchronisers, width counters, holdoff counters, pulses and all counters. If reset is asserted mid-pulse or mid-holdoff, both are aborted immediately. After release there is no holdoff in force.
- Each channel contains:
  - a 2-FF synchroniser s1 -> s2;
  - a width counter wcnt, sized clog2(MIN_WIDTH+1) bits;
  - a holdoff counter hcnt;
  - one registered pulse output.
- wcnt: cleared whenever s2=0; when s2=1 it increments, saturating at MIN_WIDTH.
- Qualification: an edge qualifies on the clock edge where wcnt_next == MIN_WIDTH and wcnt != MIN_WIDTH, i.e. the transition into saturation.
  - Qualification therefore happens once per high level. Re-arming requires s2 to return to 0.
  - A high level that is still held when holdoff expires does not qualify again.
- Acceptance: a qualified edge is accepted if hcnt==0 and enable=1.
  - The pulse register is set for exactly one cycle.
  - hcnt is loaded with HOLDOFF.
  - The channel's count increments.
- Refusal:
  - Qualified with hcnt!=0 and enable=1: no pulse, drop_count increments.
  - Qualified with enable=0: no pulse, no count change.
- hcnt decrements by 1 per cycle while nonzero. A load on the same edge takes precedence over the decrement.
- Latency: let E0 be the first clock edge that samples the input high. The pulse is high in the cycle after edge E(1+MIN_WIDTH) and low after the next edge. For the default parameters that is E3.
- Input high for fewer than MIN_WIDTH synchronised cycles: no pulse, no count.
- Simultaneous start and stop acceptance in the same cycle:
  - both pulses assert together (the downstream gate resolves priority);
  - set_count and clr_count both increment.
- Simultaneous drops on both channels in one cycle: drop_count increments by 2, saturating.
- Counter wrap: set_count and clr_count wrap from all-ones to 0 silently. drop_count holds at all-ones.
- The channels are fully independent. Holdoff on one channel never blocks the other.
- enable is sampled synchronously and takes effect on the same edge.

Test Plan:
- Reset, then start_in high for 10 cycles (MIN_WIDTH=2, HOLDOFF=8) -> exactly one set_pulse, high in the cycle after E3; set_count=1; clr_count=drop_count=0.
- start_in high for 1 cycle only -> no set_pulse, set_count stays 0. Repeat with 2 cycles aligned to the clock -> one set_pulse.
- Two start pulses (each 4 cycles high, 2 cycles low apart) -> first accepted; second qualifies while hcnt!=0, so no pulse, drop_count=1. A third pulse issued 12 cycles after the first acceptance -> accepted, set_count=2.
- start_in and stop_in rise on the same edge -> set_pulse and clr_pulse both high in the same cycle, set_count=clr_count=1.
- enable=0 during a start pulse -> no pulse and all counters unchanged. Pulse again after enable=1 -> accepted.
- Assert reset while hcnt=5 and set_count=3 -> all outputs 0 immediately. After release, a new start pulse is accepted at once (no residual holdoff) and set_count=1.
- Preload scenario: 2^CNT_W start pulses with CNT_W=4, HOLDOFF=0 -> set_count wraps to 0. Forced drops -> drop_count sticks at 15.
